// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Iterative EX-stage multiply/divide unit with architectural HI/LO
//            registers and MTHI/MTLO write port. Optional early-out for
//            multiplies when MULDIV_EARLY_OUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_is_div;
  logic                 r_neg_main;
  logic                 r_neg_rem;
  logic [WIDTH-1:0]     r_m;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [c_CW-1:0]      r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_mt_ok;
  logic                 w_last;
  logic                 w_early;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_b_zero;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rmd;

  // Operand conditioning at start: op[0]=0 selects the signed variants.
  assign w_a_neg  = ~op[0] & src_a[WIDTH-1];
  assign w_b_neg  = ~op[0] & src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;
  assign w_b_zero = (src_b == '0);

  assign w_last   = (r_cnt == c_LAST);

  // Multiply step: conditional add into the upper half, then shift right.
  assign w_addend = r_acc[0] ? {1'b0, r_m} : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;

  // Restoring divide step; the trial value never exceeds twice the divisor.
  assign w_trial  = {r_rem, r_acc[WIDTH-1]};
  assign w_ge     = (w_trial >= {1'b0, r_m});
  assign w_diff   = w_trial[WIDTH-1:0] - r_m;

  assign w_prod   = r_neg_main ? -r_acc : r_acc;
  assign w_quo    = r_neg_main ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rmd    = r_neg_rem  ? -r_rem : r_rem;

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] w_rest;
  logic [c_CW:0]    w_shamt;
  // Multiplier bits not yet consumed sit in the low WIDTH-cnt bits.
  assign w_rest  = r_acc[WIDTH-1:0] << r_cnt;
  assign w_early = (r_state == S_RUN) && !r_is_div && (w_rest == '0);
  assign w_shamt = (c_CW + 1)'(WIDTH) - {1'b0, r_cnt};
`else
  assign w_early = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FIXUP);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mt_ok     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mt_ok = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last || w_early) w_state_nxt = S_FIXUP;
      end
      S_FIXUP: w_state_nxt = S_DONE;
      S_DONE: begin
        w_mt_ok     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_accept    = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_div   <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_m        <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_is_div <= op[1];
      r_rem    <= '0;
      r_cnt    <= '0;
      if (op[1]) begin
        r_m        <= w_b_mag;
        r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
        // A zero divisor leaves the all-ones quotient unnegated.
        r_neg_main <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
        r_neg_rem  <= w_a_neg;
      end else begin
        r_m        <= w_a_mag;
        r_acc      <= {{WIDTH{1'b0}}, w_b_mag};
        r_neg_main <= w_a_neg ^ w_b_neg;
        r_neg_rem  <= 1'b0;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= w_last ? '0 : r_cnt + c_ONE;
      if (r_is_div) begin
        r_rem              <= w_ge ? w_diff : w_trial[WIDTH-1:0];
        r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_ge};
      end else begin
`ifdef MULDIV_EARLY_OUT_EN
        if (w_early) r_acc <= r_acc >> w_shamt;
        else         r_acc <= {w_sum, r_acc[WIDTH-1:1]};
`else
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == S_FIXUP) && !flush) begin
      if (r_is_div) begin
        r_hi <= w_rmd;
        r_lo <= w_quo;
      end else begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end else if (w_mt_ok && !w_accept) begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register.
- Consumes the forwarded rd1/rd2 operands and a decoded mul/div op, then computes over multiple cycles into architectural HI/LO registers.
- Raises busy, which the hazard logic uses as a stall source for ID/EX.
- Also services MTHI/MTLO writes; HI/LO are read combinationally by MFHI/MFLO in EX.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- src_a  in  WIDTH  multiplicand / dividend (rs)
- src_b  in  WIDTH  multiplier / divisor (rt)
- flush  in  1  abort in-flight operation
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight (RUN or FIXUP)
- done  out  1  one-cycle pulse, HI/LO just updated
- hi_out  out  WIDTH  HI register
- lo_out  out  WIDTH  LO register

Behaviour:
- Reset (async, any state): state=IDLE; hi_out=0; lo_out=0; busy=0; done=0; counter=0; working regs=0.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE, start=1 (flush=0):
  - Latch op.
  - Latch operand magnitudes: signed ops take two's-complement absolute value; unsigned ops pass through.
  - Record result sign: mult = sign_a^sign_b; quotient = sign_a^sign_b; remainder = sign_a.
  - counter=0; go to RUN.
- RUN: one iteration per cycle; counter increments; after WIDTH iterations (counter==WIDTH-1) go to FIXUP.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder reg WIDTH+1 bits.
- FIXUP:
  - Apply sign correction: negate the 2*WIDTH product, negate quotient, negate remainder, each per its recorded sign.
  - Write HI/LO: mult HI=product[2W-1:W], LO=product[W-1:0]; div LO=quotient, HI=remainder.
  - Go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Latency: start in cycle N -> busy=1 in cycles N+1..N+WIDTH+1; HI/LO visible and done=1 in cycle N+WIDTH+2. Default 34 cycles.
- busy is registered: 1 in RUN and FIXUP, 0 in IDLE and DONE.
- start while not in IDLE: ignored.
- Back-to-back: start asserted during DONE is ignored; the next start is accepted in the following IDLE cycle.
- Divide by zero (src_b=0), DIV and DIVU: LO=all ones, HI=src_a unmodified. No exception; same latency.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Remainder sign follows the dividend; quotient truncates toward zero.
- flush=1 in any state: next state IDLE; HI/LO unchanged; done not asserted; flush beats start in the same cycle.
- hi_we/lo_we:
  - In IDLE or DONE: write wdata on the clock edge; hi_we and lo_we may both be asserted together.
  - In RUN or FIXUP: ignored.
  - Same cycle as an accepted start: start wins and the write is dropped.
- hi_out/lo_out are direct register outputs, stable except on FIXUP, MT writes, or reset.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: for MULT/MULTU, when the remaining unshifted multiplier bits are all zero at the start of a RUN cycle, skip directly to FIXUP with the accumulator aligned to the full-iteration result.
  - Results are identical to the full-iteration case; latency is shorter.
  - Multiplier 0 gives a minimum latency of 3 cycles (start->FIXUP->DONE).
  - Divide latency is unchanged.
- Undefined: fixed WIDTH+2 latency for all ops.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> done at start+34; HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high exactly 33 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100/7 -> LO=14, HI=2.
- DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Flush at start+10 after HI=LO=0xAAAA5555 preloaded via MTHI/MTLO -> state IDLE next cycle, no done pulse, HI/LO still 0xAAAA5555. Then hi_we with wdata=0x1 while busy (new op) -> HI unchanged.
- Assert rst mid-RUN, asynchronously between clock edges -> busy=0, HI=LO=0 immediately. With MULDIV_EARLY_OUT_EN, MULTU 5*0 -> done at start+3, HI=LO=0.
